// File: rtl/leds_pkg.sv
// Shared encodings for the LED sequencer: LED width, animation modes and FSM states.
package leds_pkg;

  localparam int LED_W = 8;

  typedef enum logic [1:0] {
    MODE_WALK     = 2'b00,
    MODE_PINGPONG = 2'b01,
    MODE_COUNT    = 2'b10,
    MODE_STATIC   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } state_e;

endpackage

// File: rtl/leds_prescaler.sv
// Step-rate prescaler: counts 0..DIV-1 while enabled and flags the wrap cycle.
module leds_prescaler #(
  parameter int DIV   = 3_000_000,
  parameter int CNT_W = $clog2(DIV + 1)
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // clr wins over en so a stop or idle period always restarts the step interval
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/leds_sequencer.sv
// LED animation sequencer: start/hold/stop FSM, pattern datapath and static-pattern load port.
module leds_sequencer
  import leds_pkg::*;
#(
  parameter int DIV   = 3_000_000,
  parameter int CNT_W = $clog2(DIV + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic [1:0]       mode,
  input  logic             load_valid,
  input  logic [LED_W-1:0] load_data,
  output logic             load_ready,
  output logic             busy,
  output logic             tick,
  output logic [LED_W-1:0] LPORT
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [LED_W-1:0] pat_q, pat_d;
  logic             dir_q, dir_d;      // 0 = shifting left, 1 = shifting right
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;
  logic             load_ready_q, load_ready_d;

  logic             step;
  logic             presc_en;
  logic             presc_clr;

  // hold freezes the interval at once; stop discards a step landing on the same edge
  assign presc_en  = (state_q != IDLE) && !hold;
  assign presc_clr = (state_q == IDLE) || stop;

  leds_prescaler #(
    .DIV  (DIV),
    .CNT_W(CNT_W)
  ) u_prescaler (
    .clk (clk),
    .rstn(rstn),
    .en  (presc_en),
    .clr (presc_clr),
    .tick(step)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    led_d   = led_q;
    pat_d   = pat_q;
    dir_d   = dir_q;

    case (state_q)
      IDLE: begin
        if (load_valid && load_ready_q) begin
          pat_d = load_data;
        end
        if (start) begin
          state_d = RUN;
          mode_d  = mode_e'(mode);
          dir_d   = 1'b0;
          case (mode_e'(mode))
            MODE_WALK,
            MODE_PINGPONG: led_d = LED_W'(1);
            MODE_COUNT:    led_d = '0;
            default:       led_d = pat_q;
          endcase
        end
      end
      RUN,
      HOLD: begin
        if (stop) begin
          state_d = IDLE;
          led_d   = '0;
        end else begin
          state_d = hold ? HOLD : RUN;
          if (step) begin
            case (mode_q)
              MODE_WALK: led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
              MODE_PINGPONG: begin
                if (!dir_q) begin
                  led_d = led_q << 1;
                  if (led_q[LED_W-2]) dir_d = 1'b1;
                end else begin
                  led_d = led_q >> 1;
                  if (led_q[1]) dir_d = 1'b0;
                end
              end
              MODE_COUNT: led_d = led_q + LED_W'(1);
              default:    led_d = led_q;
            endcase
          end
        end
      end
      default: begin
        state_d = IDLE;
        led_d   = '0;
      end
    endcase

    tick_d       = step && !stop;
    busy_d       = (state_d != IDLE);
    load_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      mode_q       <= MODE_WALK;
      led_q        <= '0;
      pat_q        <= '0;
      dir_q        <= 1'b0;
      tick_q       <= 1'b0;
      busy_q       <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      led_q        <= led_d;
      pat_q        <= pat_d;
      dir_q        <= dir_d;
      tick_q       <= tick_d;
      busy_q       <= busy_d;
      load_ready_q <= load_ready_d;
    end
  end

  assign LPORT      = led_q;
  assign tick       = tick_q;
  assign busy       = busy_q;
  assign load_ready = load_ready_q;

endmodule

// File: tb/tb_leds_sequencer.sv
// Scoreboard bench for leds_sequencer with DIV=4: expected LED steps are queued at start and popped on each tick.
module tb_leds_sequencer;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic       stop;
  logic       hold;
  logic [1:0] mode;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       busy;
  logic       tick;
  logic [7:0] LPORT;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  leds_sequencer #(.DIV(DIV)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .stop      (stop),
    .hold      (hold),
    .mode      (mode),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .busy      (busy),
    .tick      (tick),
    .LPORT     (LPORT)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Ping-pong position after k steps: triangle wave over bit positions 0..7
  function automatic logic [7:0] pp_model(input int k);
    int idx;
    int pos;
    idx = k % 14;
    pos = (idx <= 7) ? idx : 14 - idx;
    return 8'(1 << pos);
  endfunction

  task automatic wait_tick(output int gap);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (tick !== 1'b1 && gap < 64);
  endtask

  task automatic consume(input string tag, input int n, input int exp_gap);
    int gap;
    for (int i = 0; i < n; i++) begin
      wait_tick(gap);
      chk_eq({tag, "_gap"}, gap, exp_gap);
      if (exp_q.size() > 0) chk_eq({tag, "_led"}, LPORT, exp_q.pop_front());
      else chk_eq({tag, "_sb_empty"}, exp_q.size(), 1);
    end
  endtask

  task automatic pulse_start(input logic [1:0] m);
    mode  = m;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  initial begin
    int tk;
    int bad;
    rstn = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0;
    mode = 2'b00; load_valid = 1'b0; load_data = 8'h00;

    // Reset values and quiet idle
    #12;
    chk_eq("rst_lport", LPORT, 8'h00);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_load_ready", load_ready, 1);
    chk_eq("rst_tick", tick, 0);
    @(negedge clk);
    rstn = 1'b1;
    bad = 0;
    repeat (20) begin
      cyc();
      if (LPORT !== 8'h00 || tick !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk_eq("idle_quiet", bad, 0);

    // Walk; mode changes after start must be ignored
    pulse_start(2'b00);
    chk_eq("walk_init", LPORT, 8'h01);
    chk_eq("walk_busy", busy, 1);
    chk_eq("walk_load_ready", load_ready, 0);
    mode = 2'b10;
    for (int k = 1; k <= 8; k++) exp_q.push_back(8'(1 << (k % 8)));
    consume("walk", 8, DIV);
    pulse_stop();
    chk_eq("walk_stop_lport", LPORT, 8'h00);
    chk_eq("walk_stop_busy", busy, 0);

    // Ping-pong
    pulse_start(2'b01);
    chk_eq("pp_init", LPORT, 8'h01);
    for (int k = 1; k <= 16; k++) exp_q.push_back(pp_model(k));
    consume("pp", 16, DIV);
    pulse_stop();

    // Count with hold, then run on through FE, FF, 00
    pulse_start(2'b10);
    chk_eq("cnt_init", LPORT, 8'h00);
    for (int k = 1; k <= 3; k++) exp_q.push_back(8'(k));
    consume("cnt", 3, DIV);
    hold = 1'b1;
    tk = 0; bad = 0;
    repeat (10) begin
      cyc();
      if (tick === 1'b1) tk++;
      if (LPORT !== 8'h03) bad++;
    end
    chk_eq("hold_ticks", tk, 0);
    chk_eq("hold_lport", bad, 0);
    chk_eq("hold_busy", busy, 1);
    hold = 1'b0;
    for (int k = 4; k <= 256; k++) exp_q.push_back(8'(k));
    consume("cnt_run", 253, DIV);
    pulse_stop();

    // Static pattern load and stalled load during RUN
    load_valid = 1'b1;
    load_data  = 8'hA5;
    chk_eq("load_ready_idle", load_ready, 1);
    cyc();
    load_valid = 1'b0;
    pulse_start(2'b11);
    chk_eq("static_init", LPORT, 8'hA5);
    repeat (5) exp_q.push_back(8'hA5);
    consume("static", 5, DIV);
    load_valid = 1'b1;
    load_data  = 8'h3C;
    bad = 0;
    repeat (6) begin
      cyc();
      if (load_ready !== 1'b0) bad++;
    end
    chk_eq("load_stalled", bad, 0);
    chk_eq("static_during_stall", LPORT, 8'hA5);
    pulse_stop();
    chk_eq("stop_load_ready", load_ready, 1);
    chk_eq("stop_static_lport", LPORT, 8'h00);
    cyc();
    load_valid = 1'b0;
    pulse_start(2'b11);
    chk_eq("stalled_load_kept", LPORT, 8'h3C);
    pulse_stop();

    // stop and start together during RUN
    pulse_start(2'b00);
    cyc(2);
    stop  = 1'b1;
    start = 1'b1;
    cyc();
    stop  = 1'b0;
    start = 1'b0;
    chk_eq("coll_lport", LPORT, 8'h00);
    chk_eq("coll_busy", busy, 0);
    cyc(3);
    chk_eq("coll_stay_idle", busy, 0);

    // stop on the tick edge suppresses tick
    pulse_start(2'b00);
    cyc(DIV - 1);
    pulse_stop();
    chk_eq("stop_tick_supp", tick, 0);
    chk_eq("stop_tick_lport", LPORT, 8'h00);

    // Asynchronous reset mid-run
    pulse_start(2'b01);
    cyc(6);
    chk_eq("pre_rst_lport", LPORT, 8'h02);
    rstn = 1'b0;
    #1;
    chk_eq("arst_lport", LPORT, 8'h00);
    chk_eq("arst_busy", busy, 0);
    chk_eq("arst_load_ready", load_ready, 1);
    chk_eq("arst_tick", tick, 0);
    @(negedge clk);
    rstn = 1'b1;
    pulse_start(2'b11);
    chk_eq("arst_pattern_cleared", LPORT, 8'h00);
    pulse_stop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
